// File: rtl/fp_acc_pkg.sv
// Shared widths, state encoding and helpers for the single-precision accumulator.
// Format: no denormals, no NaN, infinity saturates.
package fp_acc_pkg;

    localparam int E_BIT  = 8;
    localparam int F_BIT  = 23;
    localparam int W      = E_BIT + F_BIT + 1;
    localparam int BIAS   = 2 ** (E_BIT - 1) - 1;
    localparam logic [E_BIT-1:0] EXP_MAX = {E_BIT{1'b1}};
    localparam int MANT_W = F_BIT + 1;
    localparam int EXT_W  = MANT_W + 3;
    localparam int SUM_W  = EXT_W + 1;
    localparam int LZC_W  = $clog2(SUM_W + 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ALIGN = 3'd1,
        ADD   = 3'd2,
        NORM  = 3'd3,
        OUT   = 3'd4
    } state_e;

    function automatic logic [W-1:0] inf_of(input logic sign);
        return {sign, EXP_MAX, {F_BIT{1'b0}}};
    endfunction

endpackage

// File: rtl/fp_lzc.sv
// Leading-zero counter over the raw adder output; all-zero input yields W.
module fp_lzc
    import fp_acc_pkg::*;
#(
    parameter int W  = SUM_W,
    parameter int CW = $clog2(W + 1)
) (
    input  logic [W-1:0]  data_i,
    output logic [CW-1:0] count_o
);

    // Scan upward so the highest set bit determines the final count.
    always_comb begin
        count_o = CW'(W);
        for (int i = 0; i < W; i++) begin
            count_o = data_i[i] ? CW'(W - 1 - i) : count_o;
        end
    end

endmodule

// File: rtl/fp_acc.sv
// fp_acc: sums a stream of single-precision products, one product per four cycles,
// and presents the vector sum on a ready/valid port when a product tagged last retires.
module fp_acc
    import fp_acc_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    input  logic         in_last,
    output logic         in_ready,
    output logic         out_valid,
    output logic [W-1:0] out_data,
    input  logic         out_ready
);

    localparam int XW = E_BIT + 3;

    state_e             state_q;
    logic [W-1:0]       op_q;
    logic [W-1:0]       acc_q;
    logic [W-1:0]       out_data_q;
    logic [W-1:0]       byp_val_q;
    logic               last_q;
    logic               out_valid_q;
    logic               byp_q;
    logic               sign_q;
    logic               sub_q;
    logic [E_BIT-1:0]   exp_q;
    logic [EXT_W-1:0]   big_m_q;
    logic [EXT_W-1:0]   small_m_q;
    logic [SUM_W-1:0]   sum_q;

    logic               acc_inf_s;
    logic               acc_zero_s;
    logic               op_inf_s;
    logic               op_zero_s;
    logic [W-1:0]       big_s;
    logic [W-2:0]       small_mag_s;
    logic [E_BIT-1:0]   diff_s;
    logic [E_BIT-1:0]   lost_sh_s;
    logic [EXT_W-1:0]   small_ext_s;
    logic [EXT_W-1:0]   lost_s;

    logic               byp_d;
    logic [W-1:0]       byp_val_d;
    logic               sign_d;
    logic               sub_d;
    logic [E_BIT-1:0]   exp_d;
    logic [EXT_W-1:0]   big_m_d;
    logic [EXT_W-1:0]   small_m_d;
    logic [SUM_W-1:0]   sum_d;

    logic [LZC_W-1:0]   lzc_s;
    logic [EXT_W-1:0]   m_n_s;
    logic [XW-1:0]      e_n_s;
    logic [XW-1:0]      e_f_s;
    logic               rnd_s;
    logic [MANT_W:0]    mant_r_s;
    logic [F_BIT-1:0]   frac_f_s;
    logic [W-1:0]       res_s;

    assign in_ready  = (state_q == IDLE) & ~clr & ~rst;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

    // ALIGN: classify operands, order by magnitude, shift the smaller one into place.
    always_comb begin
        acc_inf_s  = (acc_q[W-2:F_BIT] == EXP_MAX);
        acc_zero_s = (acc_q[W-2:F_BIT] == {E_BIT{1'b0}});
        op_inf_s   = (op_q[W-2:F_BIT] == EXP_MAX);
        op_zero_s  = (op_q[W-2:F_BIT] == {E_BIT{1'b0}});

        byp_d     = 1'b1;
        byp_val_d = acc_q;
        if (acc_inf_s || op_zero_s) begin
            byp_val_d = acc_q;
        end else if (op_inf_s) begin
            byp_val_d = inf_of(op_q[W-1]);
        end else if (acc_zero_s) begin
            byp_val_d = op_q;
        end else begin
            byp_d = 1'b0;
        end

        if (acc_q[W-2:0] >= op_q[W-2:0]) begin
            big_s       = acc_q;
            small_mag_s = op_q[W-2:0];
        end else begin
            big_s       = op_q;
            small_mag_s = acc_q[W-2:0];
        end

        diff_s      = big_s[W-2:F_BIT] - small_mag_s[W-2:F_BIT];
        big_m_d     = {1'b1, big_s[F_BIT-1:0], 3'b000};
        small_ext_s = {1'b1, small_mag_s[F_BIT-1:0], 3'b000};
        lost_sh_s   = E_BIT'(EXT_W) - diff_s;
        lost_s      = small_ext_s << lost_sh_s;
        // Bits shifted past the sticky position only survive as a nonzero sticky.
        if (diff_s >= E_BIT'(EXT_W)) begin
            small_m_d = {{(EXT_W-1){1'b0}}, 1'b1};
        end else begin
            small_m_d = (small_ext_s >> diff_s) | {{(EXT_W-1){1'b0}}, |lost_s};
        end

        sign_d = big_s[W-1];
        exp_d  = big_s[W-2:F_BIT];
        sub_d  = acc_q[W-1] ^ op_q[W-1];
    end

    // ADD: magnitude add or subtract; big >= small so subtraction never goes negative.
    always_comb begin
        if (sub_q) begin
            sum_d = {1'b0, big_m_q} - {1'b0, small_m_q};
        end else begin
            sum_d = {1'b0, big_m_q} + {1'b0, small_m_q};
        end
    end

    fp_lzc #(
        .W  (SUM_W),
        .CW (LZC_W)
    ) u_lzc (
        .data_i  (sum_q),
        .count_o (lzc_s)
    );

    // NORM: renormalise, round to nearest even, then apply overflow/underflow limits.
    always_comb begin
        if (sum_q[SUM_W-1]) begin
            m_n_s = {sum_q[SUM_W-1:2], sum_q[1] | sum_q[0]};
            e_n_s = XW'(exp_q) + XW'(1);
        end else begin
            m_n_s = sum_q[EXT_W-1:0] << (lzc_s - LZC_W'(1));
            e_n_s = XW'(exp_q) + XW'(1) - XW'(lzc_s);
        end

        rnd_s    = m_n_s[2] & (m_n_s[1] | m_n_s[0] | m_n_s[3]);
        mant_r_s = {1'b0, m_n_s[EXT_W-1:3]} + {{MANT_W{1'b0}}, rnd_s};
        if (mant_r_s[MANT_W]) begin
            frac_f_s = mant_r_s[F_BIT:1];
            e_f_s    = e_n_s + XW'(1);
        end else begin
            frac_f_s = mant_r_s[F_BIT-1:0];
            e_f_s    = e_n_s;
        end

        // e_f_s is two's complement: the top bit marks an exponent that went negative.
        if (byp_q) begin
            res_s = byp_val_q;
        end else if (sum_q == {SUM_W{1'b0}}) begin
            res_s = {W{1'b0}};
        end else if (!e_f_s[XW-1] && (e_f_s >= XW'(EXP_MAX))) begin
            res_s = inf_of(sign_q);
        end else if (e_f_s[XW-1] || (e_f_s == {XW{1'b0}})) begin
            res_s = {W{1'b0}};
        end else begin
            res_s = {sign_q, e_f_s[E_BIT-1:0], frac_f_s};
        end
    end

    // Control FSM with the accumulator, pipeline and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            op_q        <= {W{1'b0}};
            last_q      <= 1'b0;
            acc_q       <= {W{1'b0}};
            out_valid_q <= 1'b0;
            out_data_q  <= {W{1'b0}};
            byp_q       <= 1'b0;
            byp_val_q   <= {W{1'b0}};
            sign_q      <= 1'b0;
            sub_q       <= 1'b0;
            exp_q       <= {E_BIT{1'b0}};
            big_m_q     <= {EXT_W{1'b0}};
            small_m_q   <= {EXT_W{1'b0}};
            sum_q       <= {SUM_W{1'b0}};
        end else if (clr) begin
            state_q     <= IDLE;
            acc_q       <= {W{1'b0}};
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        op_q    <= in_data;
                        last_q  <= in_last;
                        state_q <= ALIGN;
                    end
                end
                ALIGN: begin
                    byp_q     <= byp_d;
                    byp_val_q <= byp_val_d;
                    sign_q    <= sign_d;
                    sub_q     <= sub_d;
                    exp_q     <= exp_d;
                    big_m_q   <= big_m_d;
                    small_m_q <= small_m_d;
                    state_q   <= ADD;
                end
                ADD: begin
                    sum_q   <= sum_d;
                    state_q <= NORM;
                end
                NORM: begin
                    if (last_q) begin
                        out_data_q  <= res_s;
                        out_valid_q <= 1'b1;
                        acc_q       <= {W{1'b0}};
                        state_q     <= OUT;
                    end else begin
                        acc_q   <= res_s;
                        state_q <= IDLE;
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fp_acc.sv
// Scoreboard bench for fp_acc: a driver issues products and queues expected sums,
// a forked monitor pops and compares on every output handshake.
module tb_fp_acc;

    logic        clk = 1'b0;
    logic        rst;
    logic        clr;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_last;
    logic        in_ready;
    logic        out_valid;
    logic [31:0] out_data;
    logic        out_ready;

    int          checks = 0;
    int          errors = 0;
    int          ready_mode = 0;
    logic [31:0] exp_q[$];
    logic [31:0] acc_m;

    fp_acc dut (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready)
    );

    initial forever #5 clk = ~clk;

    // Consumer side: always ready, stalled, or random back-pressure.
    always @(posedge clk) begin
        #1;
        if (ready_mode == 0) out_ready = 1'b1;
        else if (ready_mode == 1) out_ready = 1'b0;
        else out_ready = 1'($urandom_range(0, 1));
    end

    // Reference: exact real arithmetic, then one rounding to single precision.
    function automatic real f2r(input logic [31:0] f);
        logic [63:0] b;
        if (f[30:23] == 8'h00) return 0.0;
        b = {f[31], 11'(int'(f[30:23]) - 127 + 1023), f[22:0], 29'h0};
        return $bitstoreal(b);
    endfunction

    function automatic logic [31:0] r2f(input real r);
        logic [63:0] b;
        int          e;
        logic [23:0] keep;
        logic [28:0] rem;
        logic [24:0] m;
        if (r == 0.0) return 32'h0;
        b    = $realtobits(r);
        e    = int'(b[62:52]) - 1023 + 127;
        keep = {1'b1, b[51:29]};
        rem  = b[28:0];
        m    = {1'b0, keep};
        if (rem > 29'h1000_0000 || (rem == 29'h1000_0000 && keep[0])) m = m + 25'd1;
        if (m[24]) begin
            m = m >> 1;
            e = e + 1;
        end
        if (e >= 255) return {b[63], 8'hFF, 23'h0};
        if (e <= 0) return 32'h0;
        return {b[63], 8'(e), m[22:0]};
    endfunction

    function automatic logic [31:0] model_add(input logic [31:0] a, input logic [31:0] b);
        if (a[30:23] == 8'hFF) return a;
        if (b[30:23] == 8'h00) return a;
        if (b[30:23] == 8'hFF) return {b[31], 8'hFF, 23'h0};
        return r2f(f2r(a) + f2r(b));
    endfunction

    function automatic logic [31:0] rand_op();
        int          r;
        logic [31:0] v;
        logic        acc_ok;
        r      = $urandom_range(0, 19);
        v      = $urandom;
        acc_ok = (acc_m[30:23] != 8'h00);
        case (r)
            0: v[30:23] = 8'h00;
            1: v[30:23] = 8'hFF;
            2: v[30:23] = 8'(250 + $urandom_range(0, 4));
            3: if (acc_ok) v = {~acc_m[31], acc_m[30:0]};
               else v[30:23] = 8'(110 + $urandom_range(0, 30));
            4: if (acc_ok) v = {~acc_m[31], acc_m[30:1], ~acc_m[0]};
               else v[30:23] = 8'(110 + $urandom_range(0, 30));
            default: v[30:23] = 8'(110 + $urandom_range(0, 30));
        endcase
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
        end
    endtask

    task automatic monitor();
        logic [31:0] e;
        forever begin
            @(negedge clk);
            if (!rst && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_out: got %h expected no output", out_data);
                end else begin
                    e = exp_q.pop_front();
                    check("out_data", out_data, e);
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called at posedge+1; returns at posedge+1 just after the accept edge.
    task automatic send(input logic [31:0] d, input logic l, input bit push);
        int guard;
        guard    = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        @(negedge clk);
        while (!in_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got in_ready 0 expected 1");
            in_valid = 1'b0;
        end else begin
            tick();
            in_valid = 1'b0;
            acc_m    = model_add(acc_m, d);
            if (l) begin
                if (push) exp_q.push_back(acc_m);
                acc_m = 32'h0;
            end
        end
    endtask

    task automatic vec2(input logic [31:0] a, input logic [31:0] b, input logic [31:0] e);
        send(a, 1'b0, 1'b0);
        send(b, 1'b1, 1'b0);
        exp_q.push_back(e);
    endtask

    task automatic vec1(input logic [31:0] a, input logic [31:0] e);
        send(a, 1'b1, 1'b0);
        exp_q.push_back(e);
    endtask

    // Three busy cycles after an accept, then either ready again or a presented sum.
    task automatic check_busy(input logic was_last);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("busy_in_ready", {31'b0, in_ready}, 32'h0);
            check("busy_out_valid", {31'b0, out_valid}, 32'h0);
        end
        @(negedge clk);
        if (was_last) check("out_valid_rise", {31'b0, out_valid}, 32'h1);
        else check("in_ready_return", {31'b0, in_ready}, 32'h1);
        tick();
    endtask

    task automatic wait_drain();
        int guard;
        guard = 0;
        while ((exp_q.size() != 0 || out_valid) && guard < 500) begin
            tick();
            guard++;
        end
        if (guard >= 500) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
        end
    endtask

    initial begin
        int guard;
        int len;
        rst      = 1'b1;
        clr      = 1'b0;
        in_valid = 1'b0;
        in_data  = 32'h0;
        in_last  = 1'b0;
        acc_m    = 32'h0;
        fork
            monitor();
        join_none

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", {31'b0, out_valid}, 32'h0);
        check("rst_out_data", out_data, 32'h0);
        check("rst_in_ready", {31'b0, in_ready}, 32'h0);
        tick();
        rst = 1'b0;

        // 1.0 + 2.0 with cycle-exact occupancy checks
        send(32'h3F800000, 1'b0, 1'b0);
        check_busy(1'b0);
        send(32'h40000000, 1'b1, 1'b0);
        exp_q.push_back(32'h40400000);
        check_busy(1'b1);
        wait_drain();

        vec2(32'h3FC00000, 32'hBFC00000, 32'h00000000);
        vec2(32'h3F800000, 32'hBF7FFFFF, 32'h33800000);
        vec2(32'h3F800000, 32'h33800000, 32'h3F800000);
        vec2(32'h3F800000, 32'h33C00000, 32'h3F800001);
        vec2(32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000);
        vec2(32'h7F800000, 32'hFF800000, 32'h7F800000);
        vec1(32'h00123456, 32'h00000000);
        wait_drain();

        // Output stall: sum and in_ready must hold while the consumer waits.
        ready_mode = 1;
        vec2(32'h3F800000, 32'h40000000, 32'h40400000);
        guard = 0;
        while (!out_valid && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        for (int i = 0; i < 5; i++) begin
            check("hold_out_valid", {31'b0, out_valid}, 32'h1);
            check("hold_out_data", out_data, 32'h40400000);
            check("hold_in_ready", {31'b0, in_ready}, 32'h0);
            @(negedge clk);
        end
        tick();
        ready_mode = 0;
        wait_drain();
        vec1(32'h3F800000, 32'h3F800000);
        wait_drain();

        // clr while a product is in ADD, then clr masking an offered product.
        send(32'h3F800000, 1'b0, 1'b0);
        tick();
        clr = 1'b1;
        @(negedge clk);
        check("clr_in_ready", {31'b0, in_ready}, 32'h0);
        tick();
        clr   = 1'b0;
        acc_m = 32'h0;
        @(negedge clk);
        check("clr_idle", {31'b0, in_ready}, 32'h1);
        tick();
        clr      = 1'b1;
        in_valid = 1'b1;
        in_data  = 32'h40000000;
        in_last  = 1'b1;
        @(negedge clk);
        check("clr_block_ready", {31'b0, in_ready}, 32'h0);
        tick();
        clr      = 1'b0;
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("clr_no_out", {31'b0, out_valid}, 32'h0);
            check("clr_no_accept", {31'b0, in_ready}, 32'h1);
        end
        tick();
        vec1(32'h40000000, 32'h40000000);
        wait_drain();

        // Reset while a last product sits in NORM.
        send(32'h3F800000, 1'b1, 1'b0);
        tick();
        tick();
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("rst_norm_out_valid", {31'b0, out_valid}, 32'h0);
        check("rst_norm_out_data", out_data, 32'h0);
        check("rst_norm_in_ready", {31'b0, in_ready}, 32'h0);
        tick();
        rst   = 1'b0;
        acc_m = 32'h0;
        repeat (5) @(negedge clk);
        check("rst_norm_quiet", {31'b0, out_valid}, 32'h0);
        tick();

        // Randomised vectors under random back-pressure.
        ready_mode = 2;
        for (int v = 0; v < 60; v++) begin
            len = $urandom_range(1, 4);
            for (int p = 0; p < len; p++) begin
                send(rand_op(), 1'(p == len - 1), 1'b1);
                repeat ($urandom_range(0, 2)) tick();
            end
        end
        ready_mode = 0;
        wait_drain();
        repeat (5) tick();
        check("queue_empty", 32'(exp_q.size()), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
